// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: scan request/result bus for mux_scan_ctrl; MUX_SCAN_CHANGE_EN adds change/chg_irq
interface mux_scan_ctrl_if;
    logic        start;
    logic        cont;
    logic [15:0] mask;
    logic [3:0]  sel;
    logic        mux_in;
    logic        busy;
    logic        done;
    logic [15:0] data;
`ifdef MUX_SCAN_CHANGE_EN
    logic [15:0] change;
    logic        chg_irq;
`endif
    modport master (
        output start, cont, mask, mux_in,
        input  sel, busy, done, data
`ifdef MUX_SCAN_CHANGE_EN
        , input change, chg_irq
`endif
    );
    modport slave (
        input  start, cont, mask, mux_in,
        output sel, busy, done, data
`ifdef MUX_SCAN_CHANGE_EN
        , output change, chg_irq
`endif
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: 16:1 mux scan sequencer building a 16-bit snapshot; MUX_SCAN_CHANGE_EN adds change/chg_irq outputs
module mux_scan_ctrl #(
    parameter int SETTLE = 1
) (
    input logic clk,
    input logic rst,
    mux_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
    state_t      state;
    logic [3:0]  cnt, sel_q, first_ch, nxt_ch;
    logic [15:0] mask_q, shadow, shadow_nx, up_mask, snap, data_q;
    logic        busy_q, done_q, launch, has_nxt, to_done;
    // next-channel search, merged sample and scan start/finish decisions
    always_comb begin
        shadow_nx = shadow;
        if (state == ST_SAMPLE) shadow_nx[sel_q] = bus.mux_in;
        up_mask = mask_q & ~((16'd2 << sel_q) - 16'd1);
        has_nxt = |up_mask;
        nxt_ch = '0;
        first_ch = '0;
        for (int i = 15; i >= 0; i--) begin
            if (up_mask[i]) nxt_ch = 4'(i);
            if (bus.mask[i]) first_ch = 4'(i);
        end
        launch = (state == ST_IDLE && bus.start) || (state == ST_DONE && bus.cont);
        to_done = (launch && bus.mask == '0) || (state == ST_SAMPLE && !has_nxt);
        snap = launch ? '0 : shadow_nx;
    end
    // scan FSM with registered sel/busy/done/data
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            sel_q  <= '0;
            mask_q <= '0;
            shadow <= '0;
            data_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= to_done;
            shadow <= snap;
            if (launch) mask_q <= bus.mask;
            if (to_done) begin
                state  <= ST_DONE;
                data_q <= snap;
                busy_q <= 1'b0;
                sel_q  <= '0;
            end else if (launch || state == ST_SAMPLE) begin
                state  <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                sel_q  <= launch ? first_ch : nxt_ch;
                cnt    <= 4'(SETTLE);
                busy_q <= 1'b1;
            end else if (state == ST_SETTLE) begin
                if (cnt <= 4'd1) state <= ST_SAMPLE;
                else cnt <= cnt - 4'd1;
            end else if (state == ST_DONE) begin
                state <= ST_IDLE;
            end
        end
    end
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.data = data_q;
`ifdef MUX_SCAN_CHANGE_EN
    logic [15:0] change_q;
    logic        irq_q;
    // bit changes between consecutive snapshots, flagged alongside done
    always_ff @(posedge clk) begin
        if (rst) begin
            change_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_q <= to_done && |(snap ^ data_q);
            if (to_done) change_q <= snap ^ data_q;
        end
    end
    assign bus.change  = change_q;
    assign bus.chg_irq = irq_q;
`endif
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: three SETTLE variants (1, 3, 0) checked per cycle against a schedule model
module tb_mux_scan_ctrl;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, cont = 1'b0;
    logic [15:0] mask = '0, pat = '0;
    logic [3:0]  sel_o [3];
    logic        busy_o [3], done_o [3];
    logic [15:0] data_o [3];
    logic [15:0] exp_data [3];
    logic [15:0] exp_chg [3];
`ifdef MUX_SCAN_CHANGE_EN
    logic [15:0] chg_o [3];
    logic        irq_o [3];
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gd
        mux_scan_ctrl_if bus ();
        mux_scan_ctrl #(.SETTLE(g == 0 ? 1 : g == 1 ? 3 : 0)) dut (.clk(clk), .rst(rst), .bus(bus));
        assign bus.start  = start;
        assign bus.cont   = cont;
        assign bus.mask   = mask;
        assign bus.mux_in = pat[bus.sel];
        assign sel_o[g]   = bus.sel;
        assign busy_o[g]  = bus.busy;
        assign done_o[g]  = bus.done;
        assign data_o[g]  = bus.data;
`ifdef MUX_SCAN_CHANGE_EN
        assign chg_o[g]   = bus.change;
        assign irq_o[g]   = bus.chg_irq;
`endif
    end

    function automatic int sv(int g);
        return g == 0 ? 1 : g == 1 ? 3 : 0;
    endfunction

    function automatic int nth_channel(logic [15:0] m, int idx);
        int c = 0;
        for (int i = 0; i < 16; i++) if (m[i]) begin
            if (c == idx) return i;
            c++;
        end
        return 0;
    endfunction

    task automatic chk(string tag, int g, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: got %0h expected %0h", tag, g, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int g = 0; g < 3; g++) begin
            exp_data[g] = '0;
            exp_chg[g] = '0;
        end
    endtask

    // k counts cycles after the start edge; in continuous mode the schedule repeats every L+1 cycles
    task automatic check_cycle(int k, logic [15:0] m, bit c);
        for (int g = 0; g < 3; g++) begin
            int s = sv(g);
            int l = $countones(m) * (s + 1);
            int ph = c ? (k - 1) % (l + 1) + 1 : k;
            logic [3:0] es = '0;
            logic eb = 1'b0, ed = 1'b0;
            if (ph <= l) begin
                eb = 1'b1;
                es = 4'(nth_channel(m, (ph - 1) / (s + 1)));
            end else if (ph == l + 1) begin
                ed = 1'b1;
                exp_chg[g] = (pat & m) ^ exp_data[g];
                exp_data[g] = pat & m;
            end
            chk("sel", g, 32'(sel_o[g]), 32'(es));
            chk("busy", g, 32'(busy_o[g]), 32'(eb));
            chk("done", g, 32'(done_o[g]), 32'(ed));
            chk("data", g, 32'(data_o[g]), 32'(exp_data[g]));
`ifdef MUX_SCAN_CHANGE_EN
            chk("change", g, 32'(chg_o[g]), 32'(exp_chg[g]));
            chk("chg_irq", g, 32'(irq_o[g]), 32'(ed && exp_chg[g] != 0));
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scan(logic [15:0] m, bit noise);
        int n = $countones(m);
        mask = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= n * 4 + 3; k++) begin
            check_cycle(k, m, 1'b0);
            if (noise && k <= n) begin
                start = 1'($urandom);
                mask = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
    endtask

    task automatic cont_run(logic [15:0] m, int cycles);
        mask = m;
        cont = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= cycles; k++) begin
            check_cycle(k, m, 1'b1);
            if (k == cycles) begin
                rst = 1'b1;
                cont = 1'b0;
            end
            tick();
        end
        rst = 1'b0;
        reset_model();
        for (int k = 0; k < 4; k++) begin
            check_cycle(1000, m, 1'b0);
            tick();
        end
    endtask

    initial begin
        reset_model();
        tick();
        tick();
        check_cycle(1000, 16'h0, 1'b0);
        rst = 1'b0;
        tick();
        check_cycle(1000, 16'h0, 1'b0);
        pat = 16'hA5C3;
        scan(16'hFFFF, 1'b0);
        pat = 16'hFFFF;
        scan(16'h8001, 1'b0);
        scan(16'h0000, 1'b0);
        pat = 16'($urandom);
        scan(16'h3C5A, 1'b1);
        pat = 16'h00FF;
        scan(16'hFFFF, 1'b0);
        pat = 16'h0F0F;
        scan(16'hFFFF, 1'b0);
        scan(16'hFFFF, 1'b0);
        for (int i = 0; i < 6; i++) begin
            pat = 16'($urandom);
            scan(16'($urandom), 1'(i % 2));
        end
        pat = 16'h5A5A;
        cont_run(16'h000F, 12);
        pat = 16'($urandom);
        cont_run(16'($urandom) | 16'h0100, 5 + int'($urandom_range(0, 25)));
        cont_run(16'h0000, 4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
